// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with configurable data width, optional parity, 1/2 stop bits
// and oversampling. tx is registered from next-state values, so it switches on the same edge as the state.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_busy,
    output logic                 tx_done_tick,
    output logic                 tx
);
    localparam int BW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 par_bit;

    assign bit_end      = baud_tick && baud_cnt == BW'(OVERSAMPLE - 1);
    assign last_data    = bit_cnt == 4'(DATA_BITS - 1);
    assign last_stop    = bit_cnt == 4'(STOP_BITS - 1);
    assign par_bit      = (PARITY == 1) ? ~^data_q : ^data_q;
    // Gated by rst so an aborted frame never reports completion.
    assign tx_done_tick = !rst && state == STOP && bit_end && last_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (state == IDLE) begin
            if (tx_start) begin
                state    <= START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                data_q   <= data_in;
                shreg    <= data_in;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
            end
        end else if (baud_tick) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                    DATA: begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                        if (last_data) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                            tx    <= (PARITY != 0) ? par_bit : 1'b1;
                        end else begin
                            tx <= shreg[1];
                        end
                    end
                    PAR: begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                    default: begin
                        bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                        if (last_stop) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: six transmitter configurations checked every cycle against a frame-level model
// (expected line = frame bit indexed by ticks since acceptance / oversample).
module tb_uart_tx_frame;
    localparam int DB[6]  = '{8, 7, 7, 8, 9, 5};
    localparam int OSA[6] = '{16, 2, 2, 16, 3, 4};
    localparam int PA[6]  = '{0, 2, 1, 1, 0, 0};
    localparam int NB[6]  = '{10, 10, 10, 12, 11, 7};
    localparam logic [15:0] LIT[6] = '{16'h034A, 16'h0200, 16'h0300, 16'h0C0E, 16'h07FE, 16'h006A};
    localparam int LEN[6] = '{160, 20, 20, 192, 33, 28};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] tick = '0;
    logic [5:0] start = '0;
    logic [5:0] busy;
    logic [5:0] done;
    logic [5:0] txo;
    logic [8:0] din [6];

    bit          rst_req = 1'b1;
    bit          noise = 1'b0;
    bit          ovr [6];
    logic [8:0]  ovr_d = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          act [6];
    int          t [6];
    int          dlen [6];
    logic [15:0] fb [6];
    logic [15:0] cap [6];
    logic [15:0] fr [6][$];
    int          lens [6][$];
    logic [8:0]  q [6][$];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_tick(tick[0]), .tx_start(start[0]), .data_in(din[0][7:0]),
        .tx_busy(busy[0]), .tx_done_tick(done[0]), .tx(txo[0]));
    uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(2), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .baud_tick(tick[1]), .tx_start(start[1]), .data_in(din[1][6:0]),
        .tx_busy(busy[1]), .tx_done_tick(done[1]), .tx(txo[1]));
    uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(2), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(tick[2]), .tx_start(start[2]), .data_in(din[2][6:0]),
        .tx_busy(busy[2]), .tx_done_tick(done[2]), .tx(txo[2]));
    uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .baud_tick(tick[3]), .tx_start(start[3]), .data_in(din[3][7:0]),
        .tx_busy(busy[3]), .tx_done_tick(done[3]), .tx(txo[3]));
    uart_tx_frame #(.DATA_BITS(9), .OVERSAMPLE(3), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst(rst), .baud_tick(tick[4]), .tx_start(start[4]), .data_in(din[4]),
        .tx_busy(busy[4]), .tx_done_tick(done[4]), .tx(txo[4]));
    uart_tx_frame #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY(0), .STOP_BITS(1)) u5 (
        .clk(clk), .rst(rst), .baud_tick(tick[5]), .tx_start(start[5]), .data_in(din[5][4:0]),
        .tx_busy(busy[5]), .tx_done_tick(done[5]), .tx(txo[5]));

    task automatic chk(input string n, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s[%0d] got=%0h exp=%0h @%0t", n, k, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] frame(input int k, input logic [8:0] d);
        logic [15:0] f = '1;
        logic        p = 1'b0;
        f[0] = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            f[i+1] = d[i];
            p ^= d[i];
        end
        if (PA[k] != 0) f[DB[k]+1] = (PA[k] == 1) ? ~p : p;
        return f;
    endfunction

    function automatic bit dir_done();
        bit r = fr[0].size() >= 2;
        for (int k = 1; k < 6; k++) r = r && fr[k].size() >= 1;
        return r;
    endfunction

    function automatic bit all_idle();
        bit r = 1'b1;
        for (int k = 0; k < 6; k++) r = r && !act[k];
        return r;
    endfunction

    task automatic step();
        logic exp_done;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_req;
        for (int k = 0; k < 6; k++) begin
            tick[k]  = (k == 5) ? (cyc % 5 == 0) : (noise && k != 0) ? 1'($urandom % 2) : 1'b1;
            start[k] = ovr[k] || q[k].size() > 0 || (noise && $urandom % 16 == 0);
            din[k]   = ovr[k] ? ovr_d : (q[k].size() > 0) ? q[k][0] : 9'($urandom);
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            exp_done = act[k] && tick[k] && !rst && t[k] == NB[k] * OSA[k] - 1;
            chk("tx", k, txo[k], act[k] ? fb[k][t[k] / OSA[k]] : 1'b1);
            chk("busy", k, busy[k], act[k]);
            chk("done", k, done[k], exp_done);
            if (act[k]) cap[k][t[k] / OSA[k]] = txo[k];
            if (act[k] && tick[k]) dlen[k]++;
            if (done[k] === 1'b1) lens[k].push_back(dlen[k]);
            if (rst) begin
                act[k] = 1'b0;
                t[k] = 0;
            end else if (act[k]) begin
                if (exp_done) begin
                    act[k] = 1'b0;
                    fr[k].push_back(cap[k]);
                end else if (tick[k]) t[k]++;
            end else if (start[k]) begin
                act[k] = 1'b1;
                t[k] = 0;
                dlen[k] = 0;
                cap[k] = '0;
                fb[k] = frame(k, din[k]);
                if (!ovr[k] && q[k].size() > 0) void'(q[k].pop_front());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) begin
            din[k] = '0;
            ovr[k] = 1'b0;
        end
        repeat (3) step();
        rst_req = 1'b0;
        q[0].push_back(9'h0A5);
        q[0].push_back(9'h03C);
        q[1].push_back(9'h000);
        q[2].push_back(9'h000);
        q[3].push_back(9'h007);
        q[4].push_back(9'h1FF);
        q[5].push_back(9'h015);
        ovr_d = 9'h012;
        for (int c = 0; c < 2000 && !dir_done(); c++) begin
            ovr[4] = (c == 20);
            step();
        end
        ovr[4] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("frame", k, (fr[k].size() > 0) ? fr[k][0] : 16'hDEAD, LIT[k]);
            chk("ticks", k, (lens[k].size() > 0) ? lens[k][0] : -1, LEN[k]);
        end
        chk("b2b_frame", 0, (fr[0].size() > 1) ? fr[0][1] : 16'hDEAD, 16'h0278);

        q[0].push_back(9'h05A);
        for (int c = 0; c < 500 && !(act[0] && t[0] / 16 == 4); c++) step();
        chk("in_bit3", 0, act[0] && t[0] / 16 == 4, 1);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rst_tx", 0, txo[0], 1);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_no_done", 0, lens[0].size(), 2);
        q[0].push_back(9'h081);
        for (int c = 0; c < 500 && fr[0].size() < 3; c++) step();
        chk("frame81", 0, (fr[0].size() > 2) ? fr[0][2] : 16'hDEAD, 16'h0302);

        noise = 1'b1;
        repeat (4000) step();
        noise = 1'b0;
        for (int c = 0; c < 3000 && !all_idle(); c++) step();
        chk("drain", 0, all_idle(), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
